mac_serial2d_seq: RTL and testbench
===================================

// Module: mac_serial2d_seq
// PURPOSE
//   Parametrised 2D digit-serial MAC (Loom style) with internal sequencer. Unsigned activation times signed weight.
//   Precision is selectable per operand and set in N-bit digits. The block sequences all digit-pair products
//   internally (m*n cycles per operand) and accumulates them into a signed accumulator. It replaces the
//   externally driven shift/sign/select control and the gated second clock of the previous serial2d MAC.
// PARAMETERS
//   A_W       8   activation input width (unsigned); multiple of N_W
//   W_W       8   weight input width (two's complement); multiple of N_W
//   N_W       4   digit width processed per cycle
//   HEADROOM  4   extra accumulator bits; ACC_W = A_W+W_W+HEADROOM
// PORTS
//   clk       in   1       single clock, rising edge
//   rst       in   1       asynchronous reset, active-high
//   clr       in   1       restart accumulation (see BEHAVIOUR)
//   a_prec    in   PA_W    activation digits m, 1..A_W/N_W; PA_W=$clog2(A_W/N_W)+1
//   w_prec    in   PW_W    weight digits n, 1..W_W/N_W; PW_W=$clog2(W_W/N_W)+1
//   in_valid  in   1       operand pair presented
//   in_ready  out  1       operand pair can be accepted this cycle
//   a         in   A_W     activation, MSB-aligned, unsigned
//   w         in   W_W     weight, MSB-aligned, signed
//   z         out  ACC_W   accumulator, signed, registered
//   z_valid   out  1       one-cycle pulse: z includes the latest operand pair
//   busy      out  1       sequencer in RUN
//   sat       out  1       sticky saturation flag (see CONFIGURATION)
// BEHAVIOUR
//   - Reset: z=0, z_valid=0, busy=0, sat=0, FSM=IDLE. in_ready=0 while rst is high.
//   - Precision: only the top m (or n) digits of a (or w) are used; lower digits are treated as zero.
//     The contribution per pair is exactly $signed({1'b0,a_masked})*$signed(w_masked).
//   - Out-of-range precision: a_prec/w_prec are sampled on accept. 0 or above max clamps to max.
//   - Handshake: accept = in_valid & in_ready. a, w, m, n and clr are captured into registers on accept.
//   - FSM states:
//     - IDLE: in_ready=1. On accept go to RUN, step 0.
//     - RUN: one digit product per cycle for m*n cycles, in anti-diagonal order.
//       Outer loop s=0..m+n-2; inner loop j=max(0,s-m+1)..min(s,n-1).
//       Product is a digit (s-j) times w digit j, digits counted from the top.
//       The a digit is always unsigned. The w digit is signed only for the top weight digit, else unsigned.
//       The product is sign-extended, shifted to its true bit weight, and added to the accumulator.
//       On the last step: z_valid=1 and z holds the new sum. in_ready=1 in the same cycle.
//       Accept on the last step stays in RUN at step 0 (no bubble). Otherwise go to IDLE.
//   - Latency: accept at cycle t -> z_valid at cycle t+m*n. Throughput is one pair per m*n cycles.
//   - clr:
//     - clr=1 on accept: the accumulator is zeroed before the first partial product of that pair.
//     - clr=1 in IDLE without accept: z=0 next cycle, sat=0, no z_valid.
//     - clr during RUN (not on accept): ignored.
//   - Intermediate sums are internal. z only updates at the end of each pair, or on an idle clr.
//   - rst mid-RUN: the pair in flight is discarded and all outputs return to reset values.
//   - Precision may change between pairs without flush; each pair uses its own captured m, n.
// CONFIGURATION
//   MAC_S2D_SAT_EN defined:
//     - each addition clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
//     - sat is set on any clamp and stays set until clr or rst.
//   Not defined:
//     - addition wraps modulo 2^ACC_W.
//     - sat is tied to 0.
// TESTING (A_W=W_W=8, N_W=4, HEADROOM=4, ACC_W=20)
//   1 m=2,n=2, a=0xFF, w=0x80, clr=1 -> z_valid 4 cycles after accept, z=-32640.
//   2 m=1,n=1, a=0xA5, w=0x7F, clr=1 -> masked 0xA0*0x70, z_valid after 1 cycle, z=17920.
//   3 m=2,n=1, a=0x03, w=0xF3, clr=1 -> w masked 0xF0=-16, z_valid after 2 cycles, z=-48.
//   4 m=n=2, in_valid held: (2,3,clr) then (5,-1) -> in_ready=1 on last step, z_valid 4 cycles apart, z=6 then z=1.
//   5 17x (0xFF,0x80): SAT_EN -> z=-524288, sat=1; without SAT_EN -> z=493696, sat=0.
//   6 rst pulse at RUN step 2 -> z=0, z_valid=0, busy=0; next pair (3,4,clr) -> z=12.

Source files
------------

// File: rtl/mac_serial2d_seq_if.sv
// Operand/result bundle for the sequenced 2D digit-serial MAC.
// The master drives operands and the handshake; the slave (the MAC) returns the
// accumulator, its valid pulse and the status flags.
interface mac_serial2d_seq_if #(
  parameter int A_W      = 8,
  parameter int W_W      = 8,
  parameter int N_W      = 4,
  parameter int HEADROOM = 4
);
  localparam int ACC_W = A_W + W_W + HEADROOM;
  localparam int PA_W  = $clog2(A_W / N_W) + 1;
  localparam int PW_W  = $clog2(W_W / N_W) + 1;

  logic                    clr;
  logic [PA_W-1:0]         a_prec;
  logic [PW_W-1:0]         w_prec;
  logic                    in_valid;
  logic                    in_ready;
  logic [A_W-1:0]          a;
  logic [W_W-1:0]          w;
  logic signed [ACC_W-1:0] z;
  logic                    z_valid;
  logic                    busy;
  logic                    sat;

  modport master (
    output clr, a_prec, w_prec, in_valid, a, w,
    input  in_ready, z, z_valid, busy, sat
  );

  modport slave (
    input  clr, a_prec, w_prec, in_valid, a, w,
    output in_ready, z, z_valid, busy, sat
  );
endinterface

// File: rtl/mac_serial2d_seq.sv
// 2D digit-serial MAC with internal sequencer: unsigned activation times signed
// weight, m*n digit products per pair walked in anti-diagonal order, summed into
// a signed accumulator that is published on z at the end of each pair.
// Optional feature macro: MAC_S2D_SAT_EN (saturating accumulate + sticky sat).
module mac_serial2d_seq #(
  parameter int A_W      = 8,
  parameter int W_W      = 8,
  parameter int N_W      = 4,
  parameter int HEADROOM = 4
) (
  input logic              clk,
  input logic              rst,
  mac_serial2d_seq_if.slave bus
);
  localparam int ACC_W = A_W + W_W + HEADROOM;
  localparam int MA    = A_W / N_W;
  localparam int MW    = W_W / N_W;
  localparam int CW    = $clog2(MA + MW) + 2;

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                  state_r;
  logic [A_W-1:0]          a_r;
  logic [W_W-1:0]          w_r;
  logic [CW-1:0]           m_r, n_r, s_r, j_r;
  logic                    clr_r;
  logic signed [ACC_W-1:0] acc_r, z_r;
  logic                    z_valid_r, sat_r;

  logic                    last_s, in_ready_s, accept_s, ovf_s;
  logic [CW-1:0]           j_hi_s, s_inc_s, s_nx_s, j_nx_s, ai_s;
  logic [N_W-1:0]          a_dig_s, w_dig_s;
  logic signed [2*N_W+1:0] a_ext_s, w_ext_s, prod_s;
  logic signed [ACC_W-1:0] prod_ext_s, add_s, base_s, res_s;
  int                      sh_amt_s;

  // Out-of-range precision (0 or above the digit count) selects full precision.
  function automatic logic [CW-1:0] clamp_prec(input logic [CW-1:0] p, input logic [CW-1:0] mx);
    return ((p == '0) || (p > mx)) ? mx : p;
  endfunction

  // Digit idx of an activation, counted from the MSB.
  function automatic logic [N_W-1:0] a_digit(input logic [A_W-1:0] v, input logic [CW-1:0] idx);
    logic [N_W-1:0] d;
    d = '0;
    for (int k = 0; k < MA; k++) begin
      d = d | ((CW'(k) == idx) ? v[A_W-1-k*N_W -: N_W] : {N_W{1'b0}});
    end
    return d;
  endfunction

  // Digit idx of a weight, counted from the MSB.
  function automatic logic [N_W-1:0] w_digit(input logic [W_W-1:0] v, input logic [CW-1:0] idx);
    logic [N_W-1:0] d;
    d = '0;
    for (int k = 0; k < MW; k++) begin
      d = d | ((CW'(k) == idx) ? v[W_W-1-k*N_W -: N_W] : {N_W{1'b0}});
    end
    return d;
  endfunction

  // Step sequencing, handshake and the current digit-pair product.
  always_comb begin
    last_s     = (s_r == (m_r + n_r - CW'(2)));
    in_ready_s = ~rst & ((state_r == IDLE) | ((state_r == RUN) & last_s));
    accept_s   = bus.in_valid & in_ready_s;

    // Inner index runs to min(s, n-1); next diagonal starts at max(0, s+1-m+1).
    j_hi_s  = (s_r < (n_r - CW'(1))) ? s_r : (n_r - CW'(1));
    s_inc_s = s_r + CW'(1);
    if (j_r < j_hi_s) begin
      s_nx_s = s_r;
      j_nx_s = j_r + CW'(1);
    end else begin
      s_nx_s = s_inc_s;
      j_nx_s = (s_inc_s >= m_r) ? (s_inc_s - m_r + CW'(1)) : {CW{1'b0}};
    end

    ai_s    = s_r - j_r;
    a_dig_s = a_digit(a_r, ai_s);
    w_dig_s = w_digit(w_r, j_r);
    a_ext_s = {{(N_W+2){1'b0}}, a_dig_s};
    // Only the top weight digit carries the sign.
    w_ext_s = {{(N_W+2){(j_r == '0) ? w_dig_s[N_W-1] : 1'b0}}, w_dig_s};
    prod_s  = a_ext_s * w_ext_s;
    prod_ext_s = {{(ACC_W-2*N_W-2){prod_s[2*N_W+1]}}, prod_s};

    // Digit pair (i, j) from the top sits at bit A_W+W_W-(i+j+2)*N_W.
    sh_amt_s = A_W + W_W - (int'(s_r) + 2) * N_W;
    add_s    = prod_ext_s <<< sh_amt_s;
    base_s   = ((s_r == '0) && clr_r) ? {ACC_W{1'b0}} : acc_r;
  end

`ifdef MAC_S2D_SAT_EN
  logic signed [ACC_W:0] sum_s;

  // Saturating add: clamp to the signed accumulator range on overflow.
  always_comb begin
    sum_s = {base_s[ACC_W-1], base_s} + {add_s[ACC_W-1], add_s};
    ovf_s = sum_s[ACC_W] ^ sum_s[ACC_W-1];
    if (ovf_s) begin
      res_s = sum_s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      res_s = sum_s[ACC_W-1:0];
    end
  end
`else
  // Wrapping add modulo 2^ACC_W; no saturation is ever reported.
  always_comb begin
    res_s = base_s + add_s;
    ovf_s = 1'b0;
  end
`endif

  // Sequencer FSM with accumulator, published result and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      a_r       <= '0;
      w_r       <= '0;
      m_r       <= '0;
      n_r       <= '0;
      s_r       <= '0;
      j_r       <= '0;
      clr_r     <= 1'b0;
      acc_r     <= '0;
      z_r       <= '0;
      z_valid_r <= 1'b0;
      sat_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          z_valid_r <= 1'b0;
          if (accept_s) begin
            state_r <= RUN;
          end else if (bus.clr) begin
            z_r   <= '0;
            acc_r <= '0;
            sat_r <= 1'b0;
          end
        end
        RUN: begin
          acc_r <= res_s;
          sat_r <= sat_r | ovf_s;
          if (last_s) begin
            z_r       <= res_s;
            z_valid_r <= 1'b1;
            state_r   <= accept_s ? RUN : IDLE;
          end else begin
            s_r       <= s_nx_s;
            j_r       <= j_nx_s;
            z_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          z_valid_r <= 1'b0;
        end
      endcase
      // Capturing a new pair restarts the step counters (overrides RUN updates).
      if (accept_s) begin
        a_r   <= bus.a;
        w_r   <= bus.w;
        m_r   <= clamp_prec(CW'(bus.a_prec), CW'(MA));
        n_r   <= clamp_prec(CW'(bus.w_prec), CW'(MW));
        s_r   <= '0;
        j_r   <= '0;
        clr_r <= bus.clr;
        if (bus.clr) begin
          sat_r <= 1'b0;
        end
      end
    end
  end

  assign bus.in_ready = in_ready_s;
  assign bus.z        = z_r;
  assign bus.z_valid  = z_valid_r;
  assign bus.busy     = (state_r == RUN);
  assign bus.sat      = sat_r;
endmodule

// File: tb/tb_mac_serial2d_seq.sv
// Scoreboard bench for mac_serial2d_seq: the driver pushes hand-computed
// results with their due cycle, a negedge monitor pops them on z_valid.
module tb_mac_serial2d_seq;
  localparam int A_W = 8, W_W = 8, N_W = 4, HEADROOM = 4;
  localparam int ACC_W = A_W + W_W + HEADROOM;

  typedef struct {
    longint z;
    int     due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb_q[$];

  mac_serial2d_seq_if #(.A_W(A_W), .W_W(W_W), .N_W(N_W), .HEADROOM(HEADROOM)) bus ();

  mac_serial2d_seq #(.A_W(A_W), .W_W(W_W), .N_W(N_W), .HEADROOM(HEADROOM)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every z_valid pulse against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.z_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_z_valid actual=%0d required=no_pulse", bus.z);
      end else begin
        e = sb_q.pop_front();
        check("z", bus.z, e.z);
        check("z_valid_cycle", cyc, e.due);
      end
    end else if (sb_q.size() > 0 && cyc > sb_q[0].due) begin
      e = sb_q.pop_front();
      total++;
      bad++;
      $display("FAIL missing_z_valid actual=none required=%0d at cycle %0d", e.z, e.due);
    end
  end

  // Present a pair from a negedge until accepted; leaves in_valid asserted.
  task automatic send(input logic [7:0] a, input logic [7:0] w, input logic [1:0] ap,
                      input logic [1:0] wp, input logic clr, input int lat,
                      input longint ez, input bit push);
    bus.a = a; bus.w = w; bus.a_prec = ap; bus.w_prec = wp;
    bus.clr = clr; bus.in_valid = 1'b1;
    for (int k = 0; k < 64; k++) begin
      #1;
      if (bus.in_ready === 1'b1) begin
        if (push) sb_q.push_back('{ez, cyc + 1 + lat});
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    total++;
    bad++;
    $display("FAIL accept_timeout actual=in_ready_low required=accept");
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    bus.clr = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && sb_q.size() > 0; k++) @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    longint v;
    logic signed [ACC_W-1:0] t;
    bus.a = '0; bus.w = '0; bus.a_prec = '0; bus.w_prec = '0;
    bus.clr = 1'b0; bus.in_valid = 1'b0;
    #1;
    check("reset_in_ready", bus.in_ready, 0);
    check("reset_z", bus.z, 0);
    check("reset_z_valid", bus.z_valid, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_sat", bus.sat, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_in_ready", bus.in_ready, 1);

    // 1: full precision, -128 * 255
    send(8'hFF, 8'h80, 2'd2, 2'd2, 1'b1, 4, -32640, 1'b1);
    check("run_busy", bus.busy, 1);
    idle(1); drain();
    // 2: one digit each, 0xA0 * 0x70
    send(8'hA5, 8'h7F, 2'd1, 2'd1, 1'b1, 1, 17920, 1'b1);
    idle(1); drain();
    // 3: m=2, n=1, weight masked to 0xF0
    send(8'h03, 8'hF3, 2'd2, 2'd1, 1'b1, 2, -48, 1'b1);
    check("z_hold_during_run", bus.z, 17920);
    idle(1); drain();
    // 4: back-to-back with in_valid held
    send(8'h02, 8'h03, 2'd2, 2'd2, 1'b1, 4, 6, 1'b1);
    send(8'h05, 8'hFF, 2'd2, 2'd2, 1'b0, 4, 1, 1'b1);
    idle(1); drain();
    // precision clamp: 0 and 3 both mean 2 digits; then accumulate without clr
    send(8'h12, 8'h34, 2'd0, 2'd3, 1'b1, 4, 936, 1'b1);
    send(8'h01, 8'h01, 2'd3, 2'd0, 1'b0, 4, 937, 1'b1);
    idle(1); drain();
    // 5: 17 x (0xFF, 0x80), saturating or wrapping
    for (int k = 1; k <= 17; k++) begin
      v = longint'(k) * -32640;
`ifdef MAC_S2D_SAT_EN
      if (v < -524288) v = -524288;
`else
      t = v[ACC_W-1:0];
      v = t;
`endif
      send(8'hFF, 8'h80, 2'd2, 2'd2, (k == 1) ? 1'b1 : 1'b0, 4, v, 1'b1);
    end
    idle(1); drain();
`ifdef MAC_S2D_SAT_EN
    check("sat_after_overflow", bus.sat, 1);
    check("z_after_overflow", bus.z, -524288);
`else
    check("sat_after_overflow", bus.sat, 0);
    check("z_after_overflow", bus.z, 493696);
`endif
    // 6: reset during RUN step 2 discards the pair
    send(8'hFF, 8'h80, 2'd2, 2'd2, 1'b1, 4, 0, 1'b0);
    idle(2);
    rst = 1'b1;
    #1;
    check("midrun_rst_z", bus.z, 0);
    check("midrun_rst_z_valid", bus.z_valid, 0);
    check("midrun_rst_busy", bus.busy, 0);
    check("midrun_rst_sat", bus.sat, 0);
    check("midrun_rst_in_ready", bus.in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    send(8'h03, 8'h04, 2'd2, 2'd2, 1'b1, 4, 12, 1'b1);
    idle(1); drain();
    // idle clr zeroes z without a z_valid pulse
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    check("idle_clr_z", bus.z, 0);
    check("idle_clr_sat", bus.sat, 0);
    idle(3);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end
endmodule
